// File: rtl/program_loader.sv
// Byte-stream program loader: takes a length byte then little-endian instruction
// byte pairs, writes them to program memory and releases the core on success.
//
// state   | meaning
// IDLE    | waiting for start, core held in reset
// LEN     | waiting for the instruction-count byte
// BYTE_LO | waiting for the low byte of the current instruction
// BYTE_HI | waiting for the high byte of the current instruction
// WRITE   | one-cycle program-memory write of the assembled word
// DONE    | load complete, core released
// ERR     | illegal length byte, core held in reset
module program_loader #(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int PC_VALUE_WIDTH    = 5,
    parameter int BYTE_WIDTH        = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [BYTE_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         pm_we,
    output logic [PC_VALUE_WIDTH-1:0]    pm_addr,
    output logic [INSTRUCTION_WIDTH-1:0] pm_wdata,
    output logic                         cpu_rst,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    localparam int DEPTH = 2 ** PC_VALUE_WIDTH;

    typedef enum logic [2:0] {
        IDLE, LEN, BYTE_LO, BYTE_HI, WRITE, DONE, ERR
    } state_t;

    state_t                    state, state_nxt;
    logic [PC_VALUE_WIDTH-1:0] addr;
    logic [PC_VALUE_WIDTH:0]   n_count;
    logic [BYTE_WIDTH-1:0]     byte_lo, byte_hi;
    logic                      accept;
    logic                      len_bad;
    logic                      last_word;

    assign accept    = in_valid && in_ready;
    assign len_bad   = (in_data == '0) || (int'(in_data) > DEPTH);
    // n_count is one bit wider than addr so a full-depth load (N = DEPTH) fits.
    assign last_word = ({1'b0, addr} == (n_count - (PC_VALUE_WIDTH+1)'(1)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            addr    <= '0;
            n_count <= '0;
            byte_lo <= '0;
            byte_hi <= '0;
        end else begin
            state <= state_nxt;
            if (state == LEN && accept && !len_bad) begin
                n_count <= (PC_VALUE_WIDTH+1)'(in_data);
                addr    <= '0;
            end
            if (state == BYTE_LO && accept) byte_lo <= in_data;
            if (state == BYTE_HI && accept) byte_hi <= in_data;
            if (state == WRITE && !last_word) addr <= addr + PC_VALUE_WIDTH'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        pm_we     = 1'b0;
        cpu_rst   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LEN;
            end
            LEN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_nxt = len_bad ? ERR : BYTE_LO;
            end
            BYTE_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_nxt = BYTE_HI;
            end
            BYTE_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_nxt = WRITE;
            end
            WRITE: begin
                pm_we     = 1'b1;
                busy      = 1'b1;
                state_nxt = last_word ? DONE : BYTE_LO;
            end
            DONE: begin
                cpu_rst = 1'b1;
                done    = 1'b1;
                if (start) state_nxt = LEN;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_nxt = LEN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pm_addr  = addr;
    assign pm_wdata = INSTRUCTION_WIDTH'({byte_hi, byte_lo});

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: expected memory writes are queued as
// bytes are driven and compared when pm_we fires.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        pm_we;
    logic [4:0]  pm_addr;
    logic [15:0] pm_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb_q[$];

    program_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every write pops one expected {addr, data}; a write with nothing queued is an extra pm_we.
    always @(negedge clk) begin
        if (pm_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("pm_we_extra", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = sb_q.pop_front();
                chk("pm_addr", {27'd0, pm_addr}, {27'd0, e[20:16]});
                chk("pm_wdata", {16'd0, pm_wdata}, {16'd0, e[15:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("len_busy", {31'd0, busy}, 32'd1);
        chk("len_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("len_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        acc = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic wait_end(input bit exp_done, input bit exp_err);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || error) break;
        end
        chk("end_done", {31'd0, done}, {31'd0, exp_done});
        chk("end_error", {31'd0, error}, {31'd0, exp_err});
        chk("end_cpu_rst", {31'd0, cpu_rst}, {31'd0, exp_done});
        chk("end_busy", {31'd0, busy}, 32'd0);
        chk("end_ready", {31'd0, in_ready}, 32'd0);
        tick();
    endtask

    task automatic load(input logic [7:0] len, input logic [15:0] words[$], input bit gaps, input bit ok);
        pulse_start();
        send_byte(len, gaps);
        if (ok) begin
            for (int i = 0; i < words.size(); i++) begin
                send_byte(words[i][7:0], gaps);
                sb_q.push_back({11'd0, 5'(i), words[i]});
                send_byte(words[i][15:8], gaps);
            end
        end
        in_valid = 1'b0;
        wait_end(ok, !ok);
        chk("sb_drain", sb_q.size(), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_we"}, {31'd0, pm_we}, 32'd0);
        chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        logic [15:0] w[$];
        logic [15:0] w3[$];
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) tick();
        chk_reset_outputs("rst0");
        rst = 1'b1;
        tick();

        // Basic two-word load
        w = '{16'h1234, 16'h5678};
        load(8'h02, w, 1'b0, 1'b1);

        // Illegal lengths
        w = {};
        load(8'h00, w, 1'b0, 1'b0);
        load(8'h21, w, 1'b0, 1'b0);

        // Full-depth load
        w = {};
        for (int i = 0; i < 32; i++) w.push_back(16'($urandom));
        load(8'h20, w, 1'b0, 1'b1);

        // Same three words with and without in_valid gaps
        w3 = '{16'hA1B2, 16'h0000, 16'hFFFF};
        load(8'h03, w3, 1'b0, 1'b1);
        load(8'h03, w3, 1'b1, 1'b1);

        // Reset in the write cycle after the second data byte
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'hCD, 1'b0);
        sb_q.push_back({11'd0, 5'd0, 16'hABCD});
        send_byte(8'hAB, 1'b0);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk_reset_outputs("midrst");
        chk("midrst_drain", sb_q.size(), 32'd0);
        rst = 1'b1;
        tick();
        w = '{16'h0F0E, 16'h1357};
        load(8'h02, w, 1'b0, 1'b1);

        // start during BYTE_HI is ignored
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h22, 1'b0);
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hi_start_busy", {31'd0, busy}, 32'd1);
        sb_q.push_back({11'd0, 5'd0, 16'h9922});
        send_byte(8'h99, 1'b0);
        in_valid = 1'b0;
        wait_end(1'b1, 1'b0);
        chk("hi_drain", sb_q.size(), 32'd0);

        // Restart from DONE: cpu_rst drops as LEN is entered
        w = '{16'h4321};
        load(8'h01, w, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 16, width of one program-memory word.
REQ-002 SHALL have parameter PC_VALUE_WIDTH, default 5, program-memory address width (depth 2**PC_VALUE_WIDTH = 32).
REQ-003 SHALL have parameter BYTE_WIDTH, default 8, width of the inbound byte stream.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1, single-cycle request to begin a load.
REQ-007 SHALL have port in_data, input, BYTE_WIDTH, inbound byte.
REQ-008 SHALL have port in_valid, input, 1, in_data valid.
REQ-009 SHALL have port in_ready, output, 1, loader can accept a byte this cycle.
REQ-010 SHALL have port pm_we, output, 1, program-memory write enable.
REQ-011 SHALL have port pm_addr, output, PC_VALUE_WIDTH, program-memory write address.
REQ-012 SHALL have port pm_wdata, output, INSTRUCTION_WIDTH, program-memory write data.
REQ-013 SHALL have port cpu_rst, output, 1, active-low reset driven to the core; 0 holds the core in reset.
REQ-014 SHALL have port busy, output, 1, load in progress.
REQ-015 SHALL have port done, output, 1, load completed successfully.
REQ-016 SHALL have port error, output, 1, load rejected due to an illegal length byte.

Function
REQ-017 SHALL implement states IDLE, LEN, BYTE_LO, BYTE_HI, WRITE, DONE, ERR.
REQ-018 SHALL accept a byte only on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL be 1 exactly in LEN, BYTE_LO and BYTE_HI.
REQ-019 SHALL, from IDLE, DONE or ERR with start=1, go to LEN next cycle; start SHALL be ignored in all other states.
REQ-020 SHALL, in LEN on acceptance, treat the byte as instruction count N; N=0 or N>2**PC_VALUE_WIDTH -> ERR; otherwise store N, clear write address to 0, -> BYTE_LO.
REQ-021 SHALL, in BYTE_LO on acceptance, capture the low byte -> BYTE_HI; in BYTE_HI on acceptance, capture the high byte -> WRITE.
REQ-022 SHALL, in WRITE, assert pm_we=1 for exactly one cycle with pm_addr = current address and pm_wdata = {high byte, low byte}; this is the cycle after the high byte is accepted.
REQ-023 SHALL, leaving WRITE, go to DONE if address = N-1, else increment the address and go to BYTE_LO; the address SHALL never wrap (N=32 ends at address 31).
REQ-024 SHALL hold pm_we=0 in every state other than WRITE; pm_addr and pm_wdata are don't-care when pm_we=0.
REQ-025 SHALL stall indefinitely in LEN, BYTE_LO and BYTE_HI while in_valid=0, with no state or address change.
REQ-026 SHALL drive cpu_rst=1 only in DONE and cpu_rst=0 in all other states; a new start from DONE SHALL return cpu_rst to 0 in the cycle LEN is entered.
REQ-027 SHALL drive busy=1 in LEN, BYTE_LO, BYTE_HI and WRITE; done=1 only in DONE; error=1 only in ERR.
REQ-028 SHALL leave earlier-written memory words untouched on error or reset; no rollback.

Reset
REQ-029 SHALL, on a rising edge with rst=0 in any state, including mid-load, enter IDLE. After that edge, in_ready=0, pm_we=0, cpu_rst=0, busy=0, done=0, error=0, address=0 and N=0.
REQ-030 SHALL take precedence over start and in_valid for reset in the same cycle.

Verification
REQ-031 start; bytes 0x02, 0x34, 0x12, 0x78, 0x56 with in_valid held 1 -> pm_we pulses at addr 0 data 0x1234 and at addr 1 data 0x5678, then done=1, cpu_rst=1.
REQ-032 start; length 0x00 -> error=1, cpu_rst=0, no pm_we; a later start with length 0x21 (33) -> error=1 again.
REQ-033 Length 0x20 with 64 data bytes -> 32 writes at addresses 0..31 in order, then DONE, with no address wrap.
REQ-034 Random in_valid gaps (about 50 % duty) during a 3-instruction load -> identical writes to the gap-free case, with no extra or missing pm_we.
REQ-035 rst=0 after the second data byte of a 2-instruction load -> next cycle IDLE with all outputs at reset values; a new start then completes normally.
REQ-036 start pulsed during BYTE_HI -> ignored; in DONE, start -> cpu_rst falls to 0 the next cycle and a new load begins.
